// File: rtl/demux12_8bit_buf.sv
// Buffered 1-to-2 byte demux: each accepted byte is steered by S into one of two DEPTH-entry FIFOs.
// Optional DEMUX12_STATS_EN adds per-output push counters (Cnt0/Cnt1) and a registered Stall flag.

module demux12_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       i_push,
  input  logic [7:0] i_dat,
  input  logic       i_pop,
  output logic [7:0] o_dat,
  output logic       o_full,
  output logic       o_empty
);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_cnt;

  // Storage is cleared on reset so the head reads 8'h00 while empty.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_dat;
        r_wr        <= r_wr + PTR_ONE;
      end
      if (i_pop) r_rd <= r_rd + PTR_ONE;
      if (i_push && !i_pop)      r_cnt <= r_cnt + CNT_ONE;
      else if (!i_push && i_pop) r_cnt <= r_cnt - CNT_ONE;
    end
  end

  assign o_dat   = r_mem[r_rd];
  assign o_full  = (r_cnt == CNT_FULL);
  assign o_empty = (r_cnt == '0);
endmodule

module demux12_8bit_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] I,
  input  logic       S,
  input  logic       I_valid,
  output logic       I_ready,
  output logic [7:0] Y0,
  output logic       Y0_valid,
  input  logic       Y0_ready,
  output logic [7:0] Y1,
  output logic       Y1_valid,
  input  logic       Y1_ready,
`ifdef DEMUX12_STATS_EN
  output logic [7:0] Cnt0,
  output logic [7:0] Cnt1,
  output logic       Stall
`else
  output logic       o_unused_nc
`endif
);
  logic w_full0, w_full1, w_empty0, w_empty1;
  logic w_push0, w_push1, w_pop0, w_pop1;

  // Ready depends only on S and the registered occupancy; a full FIFO never passes through.
  assign I_ready  = S ? ~w_full1 : ~w_full0;
  assign w_push0  = I_valid & I_ready & ~S;
  assign w_push1  = I_valid & I_ready &  S;
  assign Y0_valid = ~w_empty0;
  assign Y1_valid = ~w_empty1;
  assign w_pop0   = Y0_valid & Y0_ready;
  assign w_pop1   = Y1_valid & Y1_ready;

  demux12_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo0 (
    .Clk(Clk), .Reset(Reset), .i_push(w_push0), .i_dat(I), .i_pop(w_pop0),
    .o_dat(Y0), .o_full(w_full0), .o_empty(w_empty0)
  );

  demux12_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo1 (
    .Clk(Clk), .Reset(Reset), .i_push(w_push1), .i_dat(I), .i_pop(w_pop1),
    .o_dat(Y1), .o_full(w_full1), .o_empty(w_empty1)
  );

`ifdef DEMUX12_STATS_EN
  logic [7:0] r_cnt0, r_cnt1;
  logic       r_stall;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_cnt0  <= 8'h00;
      r_cnt1  <= 8'h00;
      r_stall <= 1'b0;
    end else begin
      if (w_push0 && r_cnt0 != 8'hFF) r_cnt0 <= r_cnt0 + 8'd1;
      if (w_push1 && r_cnt1 != 8'hFF) r_cnt1 <= r_cnt1 + 8'd1;
      r_stall <= I_valid & ~I_ready;
    end
  end

  assign Cnt0  = r_cnt0;
  assign Cnt1  = r_cnt1;
  assign Stall = r_stall;
`else
  assign o_unused_nc = 1'b0;
`endif
endmodule

// File: tb/tb_demux12_8bit_buf.sv
// Randomised scoreboard bench for demux12_8bit_buf: queue-per-output reference model, decoupled driver and monitor.
module tb_demux12_8bit_buf;
  localparam int DEPTH = 4;
  localparam int MAXW  = 60;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] I;
  logic       S;
  logic       I_valid;
  logic       I_ready;
  logic [7:0] Y0, Y1;
  logic       Y0_valid, Y1_valid;
  logic       Y0_ready, Y1_ready;
`ifdef DEMUX12_STATS_EN
  logic [7:0] Cnt0, Cnt1;
  logic       Stall;
`else
  logic       nc;
`endif

  int vectors = 0;
  int errors  = 0;
  byte unsigned q0[$];
  byte unsigned q1[$];
  int mode0 = 0, mode1 = 0;   // 0: hold low, 1: hold high, 2: random
  int exp_cnt0 = 0, exp_cnt1 = 0;
  bit exp_stall = 0;

  demux12_8bit_buf #(.DEPTH(DEPTH), .AW(2)) dut (
    .Clk(Clk), .Reset(Reset), .I(I), .S(S), .I_valid(I_valid), .I_ready(I_ready),
    .Y0(Y0), .Y0_valid(Y0_valid), .Y0_ready(Y0_ready),
    .Y1(Y1), .Y1_valid(Y1_valid),
`ifdef DEMUX12_STATS_EN
    .Cnt0(Cnt0), .Cnt1(Cnt1), .Stall(Stall),
`else
    .o_unused_nc(nc),
`endif
    .Y1_ready(Y1_ready)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Consumer ready drivers, updated just after each rising edge.
  always @(posedge Clk) begin
    #1;
    Y0_ready = (mode0 == 2) ? 1'($urandom % 2) : (mode0 == 1);
    Y1_ready = (mode1 == 2) ? 1'($urandom % 2) : (mode1 == 1);
  end

  // Monitor: compares outputs against the model heads at the falling edge, retires pops at the rising edge.
  always begin
    bit p0, p1;
    p0 = 0; p1 = 0;
    @(negedge Clk);
    if (Reset) begin
      exp_stall = 0;
    end else begin
      chk("y0_valid", 32'(Y0_valid), 32'(q0.size() > 0));
      chk("y1_valid", 32'(Y1_valid), 32'(q1.size() > 0));
      if (q0.size() > 0) chk("y0_data", 32'(Y0), 32'(q0[0]));
      if (q1.size() > 0) chk("y1_data", 32'(Y1), 32'(q1[0]));
      p0 = Y0_valid && Y0_ready;
      p1 = Y1_valid && Y1_ready;
`ifdef DEMUX12_STATS_EN
      chk("stall", 32'(Stall), 32'(exp_stall));
      exp_stall = I_valid && !(S ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
`endif
    end
    @(posedge Clk);
    if (p0 && q0.size() > 0) void'(q0.pop_front());
    if (p1 && q1.size() > 0) void'(q1.pop_front());
  end

  // Offers one byte; the model queue receives it on the edge where the DUT takes it.
  task automatic send(input byte unsigned d, input bit s);
    bit done = 0;
    I = d; S = s; I_valid = 1'b1;
    for (int w = 0; w < MAXW && !done; w++) begin
      @(negedge Clk);
      chk("i_ready", 32'(I_ready), 32'(s ? (q1.size() < DEPTH) : (q0.size() < DEPTH)));
      if (I_ready) begin
        @(posedge Clk);
        if (s) begin q1.push_back(d); if (exp_cnt1 < 255) exp_cnt1++; end
        else   begin q0.push_back(d); if (exp_cnt0 < 255) exp_cnt0++; end
        done = 1;
        #1;
      end
    end
    if (!done) begin
      vectors++; errors++;
      $display("FAIL send_timeout data %0h sel %0d: got no accept expected accept within %0d cycles", d, s, MAXW);
      @(posedge Clk); #1;
    end
    I_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    mode0 = 1; mode1 = 1;
    while ((q0.size() > 0 || q1.size() > 0) && w < 200) begin
      @(posedge Clk); w++;
    end
    vectors++;
    if (q0.size() > 0 || q1.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d bytes left expected 0/0", q0.size(), q1.size());
    end
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset = 1'b1; I = 8'h00; S = 1'b0; I_valid = 1'b0; Y0_ready = 1'b0; Y1_ready = 1'b0;
    #2;
    chk("rst_y0", 32'(Y0), 32'h0);
    chk("rst_y1", 32'(Y1), 32'h0);
    chk("rst_y0_valid", 32'(Y0_valid), 32'h0);
    chk("rst_y1_valid", 32'(Y1_valid), 32'h0);
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;

    // Single byte held at the output while its consumer stalls.
    send(8'hA5, 0);
    repeat (4) @(posedge Clk);
    #1;

    // Fill FIFO 1, probe ready on both selects, then push into it while it drains.
    for (int k = 1; k <= 4; k++) send(8'(k), 1);
    S = 1'b1; @(negedge Clk);
    chk("full1_ready_s1", 32'(I_ready), 32'h0);
    S = 1'b0; @(negedge Clk);
    chk("full1_ready_s0", 32'(I_ready), 32'h1);
    @(posedge Clk); #1;
    mode1 = 1;
    send(8'h05, 1);
    mode1 = 0;
    drain();

    // Interleaved traffic with both consumers ready.
    send(8'h10, 0); send(8'h20, 1); send(8'h30, 0); send(8'h40, 1);
    drain();

    // Asynchronous reset between edges with FIFO 0 partly full.
    mode0 = 0; mode1 = 0;
    @(posedge Clk); #1;
    send(8'h61, 0); send(8'h62, 0); send(8'h63, 0);
    @(negedge Clk); #2;
    Reset = 1'b1; #1;
    chk("arst_y0_valid", 32'(Y0_valid), 32'h0);
    chk("arst_y0", 32'(Y0), 32'h0);
    chk("arst_y1_valid", 32'(Y1_valid), 32'h0);
    q0.delete(); q1.delete(); exp_cnt0 = 0; exp_cnt1 = 0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    S = 1'b0; @(negedge Clk);
    chk("post_rst_ready", 32'(I_ready), 32'h1);
    chk("post_rst_empty0", 32'(Y0_valid), 32'h0);
`ifdef DEMUX12_STATS_EN
    chk("post_rst_cnt0", 32'(Cnt0), 32'h0);
`endif
    @(posedge Clk); #1;

    // Random traffic with random back-pressure on both consumers.
    mode0 = 2; mode1 = 2;
    for (int n = 0; n < 300; n++) begin
      send(8'($urandom), 1'($urandom % 2));
      if ($urandom % 4 == 0) begin @(posedge Clk); #1; end
    end
    drain();

`ifdef DEMUX12_STATS_EN
    mode0 = 1;
    for (int n = 0; n < 300; n++) send(8'($urandom), 0);
    drain();
    chk("cnt0_sat", 32'(Cnt0), 32'(exp_cnt0));
    chk("cnt0_ff", 32'(Cnt0), 32'hFF);
    chk("cnt1", 32'(Cnt1), 32'(exp_cnt1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
